// File: rtl/brq_pkg.sv
// Shared types and defaults for the branch resolve queue.
package brq_pkg;

  localparam int unsigned BRQ_DEPTH = 8;
  localparam int unsigned BRQ_PC_W  = 32;
  localparam int unsigned BRQ_CNT_W = 32;

  // One in-flight branch: its PC and the predictor's taken guess.
  typedef struct packed {
    logic [BRQ_PC_W-1:0] pc;
    logic                pred;
  } brq_entry_t;

  function automatic int unsigned brq_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/brq_ring.sv
// Circular buffer of predicted branches with push, pop and flush-to-head.
module brq_ring
  import brq_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  brq_entry_t                   push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output brq_entry_t                   head_entry,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = brq_ptr_w(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  brq_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]       head_q;
  logic [PTR_W-1:0]       tail_q;
  logic [OCC_W-1:0]       count_q;

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= push_entry;
  end

  // Flush pops the head and drops everything younger, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= head_q + PTR_W'(1);
      tail_q  <= head_q + PTR_W'(1);
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_entry = mem[head_q];
  assign count      = count_q;
  assign full       = (count_q == OCC_W'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch tracker: trains the predictor and flags mispredicts on resolve.
// Optional statistics counters are built when BRQ_STATS_EN is defined.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int unsigned DEPTH = BRQ_DEPTH,
  parameter int unsigned PC_W  = BRQ_PC_W,
  parameter int unsigned CNT_W = BRQ_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [PC_W-1:0]            push_pc,
  input  logic                       push_pred,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic                       train_valid,
  output logic [PC_W-1:0]            train_pc,
  output logic                       train_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err_underflow,
  output logic [CNT_W-1:0]           stat_branches,
  output logic [CNT_W-1:0]           stat_mispredicts
);

  brq_entry_t push_entry;
  brq_entry_t head_entry;
  logic       full;
  logic       empty;
  logic       push_fire;
  logic       resolve_fire;
  logic       mispredict_c;

  assign push_ready   = !full && !reset;
  assign push_fire    = push_valid && push_ready;
  assign resolve_fire = resolve_valid && !empty;
  assign mispredict_c = resolve_fire && (head_entry.pred != resolve_taken);

  assign push_entry.pc   = BRQ_PC_W'(push_pc);
  assign push_entry.pred = push_pred;

  brq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .reset      (reset),
    .push       (push_fire),
    .push_entry (push_entry),
    .pop        (resolve_fire),
    .flush      (mispredict_c),
    .head_entry (head_entry),
    .count      (occupancy),
    .full       (full),
    .empty      (empty)
  );

  // Training strobe and redirect pulse, one cycle after the resolve edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      train_valid   <= 1'b0;
      train_pc      <= '0;
      train_taken   <= 1'b0;
      mispredict    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      train_valid <= resolve_fire;
      mispredict  <= mispredict_c;
      if (resolve_fire) begin
        train_pc    <= PC_W'(head_entry.pc);
        train_taken <= resolve_taken;
      end
      if (resolve_valid && empty) err_underflow <= 1'b1;
    end
  end

`ifdef BRQ_STATS_EN
  logic [CNT_W-1:0] branches_q;
  logic [CNT_W-1:0] mispredicts_q;

  // Saturating counters updated on the resolve edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      if (resolve_fire && (branches_q != '1))   branches_q    <= branches_q + CNT_W'(1);
      if (mispredict_c && (mispredicts_q != '1)) mispredicts_q <= mispredicts_q + CNT_W'(1);
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every branch the hybrid predictor has predicted until execute resolves it, then generates the predictor's training strobe and the pipeline's mispredict/flush signal. Sits between fetch (push side, fed by the predictor output) and execute (resolve side); its train_* outputs drive the predictor's branch_valid/is_branch/branch_taken/pc training inputs. Branches resolve strictly in program order.

## Interface
- DEPTH, 8, in-flight branch entries; power of two, ≥2
- PC_W, 32, branch PC width
- CNT_W, 32, statistics counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- push_valid  in  1  fetch presents a predicted branch
- push_ready  out  1  queue can accept (= !full && !reset)
- push_pc  in  PC_W  branch PC
- push_pred  in  1  predictor's taken prediction
- resolve_valid  in  1  execute resolves oldest branch (no ready; always accepted)
- resolve_taken  in  1  actual outcome
- train_valid  out  1  one-cycle training strobe to predictor
- train_pc  out  PC_W  PC of trained branch
- train_taken  out  1  actual outcome
- mispredict  out  1  one-cycle pulse; redirect fetch, flush younger
- occupancy  out  $clog2(DEPTH)+1  entries held
- err_underflow  out  1  sticky: resolve seen while empty
- stat_branches, stat_mispredicts  out  CNT_W  counters (see Configuration)

## Operation
- Storage: circular buffer of {pc, pred}; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; separate count register.
- Push handshake: push_valid && push_ready at posedge writes tail, tail+1, count+1.
- Resolve: resolve_valid with count>0 pops head. Compare head.pred vs resolve_taken combinationally; result registered.
- Correct prediction: pop only.
- Mispredict: pop head, discard all remaining entries (count←0, tail←head+1); a push handshaking in the same cycle is completed but discarded (it is younger).
- Correct resolve + push same cycle: both happen; count unchanged. Allowed when full? No: push_ready is low when full regardless of resolve (no bypass).
- Resolve while empty: ignored, no train strobe, err_underflow←1 until reset.
- Reset mid-operation: all entries dropped, pointers/count 0, pending outputs cleared next edge.

## Timing
- Reset values: push_ready 0 during reset, 1 first cycle after; train_valid 0, train_pc 0, train_taken 0, mispredict 0, occupancy 0, err_underflow 0, counters 0.
- train_valid/train_pc/train_taken/mispredict registered: asserted exactly one cycle after the resolve edge, for one cycle.
- Back-to-back resolves produce back-to-back train strobes; after a mispredict, occupancy reads 0 (or 0 plus nothing) the following cycle.
- Push-to-resolvable latency: entry is head-eligible the cycle after its push edge.
- occupancy registered, reflects state after the last edge.

## Configuration
- BRQ_STATS_EN defined: stat_branches increments per accepted resolve, stat_mispredicts per mispredict; both saturate at all-ones; update same edge as resolve.
- Undefined: counter logic absent, both outputs tied to 0.

## Structure
- Package brq_pkg: entry struct {pc, pred}, default DEPTH/PC_W/CNT_W constants, pointer-width function.
- One sub-module brq_ring: circular buffer storage + head/tail/count with push, pop, and flush-to-head inputs; top holds compare, output registers, error flag, counters.

## Test plan
- Push pc 0x100 pred 1, resolve taken 1 -> next cycle train_valid=1, train_pc=0x100, train_taken=1, mispredict=0, occupancy 0.
- Push 8 entries (DEPTH 8) -> push_ready=0, occupancy 8; correct resolve + push_valid same cycle -> push not taken, occupancy 7.
- Push pcs 0x10,0x14,0x18 pred 0; resolve taken 1 -> mispredict=1, train_pc=0x10, occupancy 0; concurrent push 0x1C discarded.
- Resolve with empty queue -> no train_valid, err_underflow=1 and stays 1 until reset.
- 20 push/resolve pairs wrapping pointers twice, 5 mispredicts, BRQ_STATS_EN -> stat_branches 20, stat_mispredicts 5; without macro both 0.
- Assert reset with 4 entries in flight -> occupancy 0, all outputs at reset values, next resolve flags err_underflow.
